// File: rtl/ms_pkg.sv
// Shared board geometry and controller state encoding for the minesweeper pool.
package ms_pkg;

    localparam int ROWS  = 8;
    localparam int COLS  = 8;
    localparam int N     = ROWS * COLS;
    localparam int POS_W = $clog2(N);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SPREAD = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

endpackage

// File: rtl/ms_flood_ctrl_if.sv
// Cell-open request handshake between the game FSM and the flood controller.
interface ms_flood_ctrl_if #(
    parameter int POS_W = ms_pkg::POS_W
);
    logic             req_valid;
    logic             req_ready;
    logic [POS_W-1:0] req_pos;

    modport master (output req_valid, output req_pos, input req_ready);
    modport slave  (input req_valid, input req_pos, output req_ready);
endinterface

// File: rtl/ms_neighbor.sv
// Combinational 8-neighbourhood mask: a cell is set if any adjacent cell is set.
module ms_neighbor #(
    parameter int ROWS = ms_pkg::ROWS,
    parameter int COLS = ms_pkg::COLS
) (
    input  logic [ROWS*COLS-1:0] cells_i,
    output logic [ROWS*COLS-1:0] nbr_o
);

    // Zero border around the board keeps column 0 and column COLS-1 apart.
    logic [ROWS+1:0][COLS+1:0] pad;

    for (genvar i = 0; i < COLS + 2; i++) begin : g_pad_tb
        assign pad[0][i]      = 1'b0;
        assign pad[ROWS+1][i] = 1'b0;
    end

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        assign pad[r+1][0]      = 1'b0;
        assign pad[r+1][COLS+1] = 1'b0;
        for (genvar c = 0; c < COLS; c++) begin : g_col
            assign pad[r+1][c+1] = cells_i[r*COLS+c];
            assign nbr_o[r*COLS+c] = pad[r][c]   | pad[r][c+1]   | pad[r][c+2]
                                   | pad[r+1][c]                 | pad[r+1][c+2]
                                   | pad[r+2][c] | pad[r+2][c+1] | pad[r+2][c+2];
        end
    end

endmodule

// File: rtl/ms_flood_ctrl.sv
// Minesweeper open/flood-fill sequencer: owns the open map, reports hit and win.
module ms_flood_ctrl #(
    parameter int ROWS   = ms_pkg::ROWS,
    parameter int COLS   = ms_pkg::COLS,
    parameter int PASS_W = 7
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    ms_flood_ctrl_if.slave         req,
    input  logic [ROWS*COLS-1:0]   mine,
    input  logic [ROWS*COLS-1:0]   flag,
    input  logic [ROWS*COLS-1:0]   doubt,
    output logic [ROWS*COLS-1:0]   open_q,
    output logic                   busy,
    output logic                   done,
    output logic                   hit,
    output logic                   win,
    output logic [PASS_W-1:0]      passes
);
    import ms_pkg::*;

    localparam int                NC       = ROWS * COLS;
    localparam logic [PASS_W-1:0] PASS_MAX = PASS_W'(NC + 1);

    logic [1:0]        state_q, state_d;
    logic [NC-1:0]     seed_q, seed_d;
    logic [NC-1:0]     open_d;
    logic              hit_q, hit_d;
    logic              win_q, win_d;
    logic [PASS_W-1:0] passes_q, passes_d;

    logic [NC-1:0]     nbr_mine, nbr_open, zero, check, should_open;

    ms_neighbor #(.ROWS(ROWS), .COLS(COLS)) u_nbr_mine (
        .cells_i (mine),
        .nbr_o   (nbr_mine)
    );

    assign zero = ~nbr_mine;

    // Open zero cells propagate the flood to their whole neighbourhood.
    ms_neighbor #(.ROWS(ROWS), .COLS(COLS)) u_nbr_open (
        .cells_i (open_q & zero & ~mine),
        .nbr_o   (nbr_open)
    );

    assign check       = seed_q | nbr_open;
    assign should_open = check & ~open_q & ~flag & ~doubt;

    assign req.req_ready = (state_q == ST_IDLE);
    assign busy          = (state_q != ST_IDLE);
    assign done          = (state_q == ST_DONE);
    assign hit           = hit_q;
    assign win           = win_q;
    assign passes        = passes_q;

    always_comb begin
        state_d  = state_q;
        seed_d   = seed_q;
        open_d   = open_q;
        hit_d    = hit_q;
        win_d    = win_q;
        passes_d = passes_q;
        case (state_q)
            ST_IDLE: begin
                if (req.req_valid) begin
                    if (hit_q || win_q || open_q[req.req_pos] ||
                        flag[req.req_pos] || doubt[req.req_pos]) begin
                        state_d = ST_DONE;
                    end else if (mine[req.req_pos]) begin
                        open_d[req.req_pos] = 1'b1;
                        hit_d               = 1'b1;
                        state_d             = ST_DONE;
                    end else begin
                        seed_d              = '0;
                        seed_d[req.req_pos] = 1'b1;
                        passes_d            = '0;
                        state_d             = ST_SPREAD;
                    end
                end
            end
            ST_SPREAD: begin
                open_d   = open_q | should_open;
                passes_d = passes_q + 1'b1;
                seed_d   = '0;
                // The pass limit only trips if flag/doubt move while busy.
                if (should_open == '0 || passes_d == PASS_MAX) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if ((&(open_q | mine)) && !hit_q) begin
                    win_d = 1'b1;
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            state_q  <= ST_IDLE;
            seed_q   <= '0;
            open_q   <= '0;
            hit_q    <= 1'b0;
            win_q    <= 1'b0;
            passes_q <= '0;
        end else begin
            state_q  <= state_d;
            seed_q   <= seed_d;
            open_q   <= open_d;
            hit_q    <= hit_d;
            win_q    <= win_d;
            passes_q <= passes_d;
        end
    end

endmodule
